// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the synchronous single-port RAM:
//   - write-cycle read-port behaviour selectors (WR_MODE values)
//   - clear-sequencer FSM state encoding
package ram_pkg;

    localparam int RAM_READ_FIRST  = 0;   // data_out shows the old word on a write
    localparam int RAM_WRITE_FIRST = 1;   // data_out shows the new word on a write
    localparam int RAM_NO_CHANGE   = 2;   // data_out holds on a write

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_sp_sync_array.sv
// ram_array
// Plain synchronous storage: one write port and one registered read port
// sharing a single address. The read register samples the word present
// before any same-edge write. Storage and read register have no reset.
// Ports:
//   i_clk    rising-edge clock
//   i_we     write enable: mem[i_addr] <= i_wdata
//   i_rd     read enable:  o_rdata <= mem[i_addr] (pre-write contents)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data
module ram_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_rd,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_rd) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sp_sync.sv
// ram_sp_sync
// Synchronous single-port RAM with a built-in clear sequencer.
// After reset (or a clear_in request) every word is written with INIT_VALUE,
// one address per cycle; user accesses are refused while that runs.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   enable_in  access request for this cycle
//   we_in      1 = write, 0 = read
//   addr_in    word address
//   data_in    write data
//   clear_in   request to re-clear the whole array (ignored while clearing)
//   data_out   registered read data (1-cycle latency)
//   valid_out  data_out holds the result of a read issued on the previous edge
//   busy_out   clear sequencer active
//   err_out    one-cycle pulse: an access was attempted while busy
module ram_sp_sync
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    WR_MODE    = RAM_READ_FIRST,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy_out,
    output logic                  err_out
);

    ram_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_valid;
    logic                  r_err;
    // data_out is either the array read register or a local copy of the last
    // write data (WRITE_FIRST writes). Reset selects the local copy, held at 0.
    logic                  r_use_wdata;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_clearing;
    logic                  w_clr_last;   // terminal flag: this edge writes DEPTH-1
    logic                  w_user;
    logic                  w_we;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_clearing = (r_state == RAM_CLEAR);
    assign w_clr_last = &r_clr_addr;
    assign w_user     = !w_clearing && enable_in;

    // Sequencer owns the port while clearing; user accesses are dropped.
    assign w_we    = w_clearing ? 1'b1       : (w_user && we_in);
    assign w_addr  = w_clearing ? r_clr_addr : addr_in;
    assign w_wdata = w_clearing ? INIT_VALUE : data_in;
    // READ_FIRST writes also load the read register, capturing the old word.
    assign w_rd    = w_user && (!we_in || (WR_MODE == RAM_READ_FIRST));

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_rd    (w_rd),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= RAM_CLEAR;
            r_clr_addr  <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_use_wdata <= 1'b1;
            r_wdata     <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                RAM_CLEAR: begin
                    r_err      <= enable_in;
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (w_clr_last) r_state <= RAM_READY;
                end
                RAM_READY: begin
                    if (enable_in) begin
                        if (!we_in) begin
                            r_valid     <= 1'b1;
                            r_use_wdata <= 1'b0;
                        end else if (WR_MODE == RAM_WRITE_FIRST) begin
                            r_use_wdata <= 1'b1;
                            r_wdata     <= data_in;
                        end else if (WR_MODE == RAM_READ_FIRST) begin
                            r_use_wdata <= 1'b0;
                        end
                    end
                    // The access above is still served on this edge.
                    if (clear_in) begin
                        r_state    <= RAM_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                default: r_state <= RAM_CLEAR;
            endcase
        end
    end

    assign data_out  = r_use_wdata ? r_wdata : w_rdata;
    assign valid_out = r_valid;
    assign err_out   = r_err;
    assign busy_out  = w_clearing;

endmodule

// File: tb/tb_ram_sp_sync.sv
module tb_ram_sp_sync;
    import ram_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, we = 1'b0, clr = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout_rf, dout_wf, dout_nc;
    logic       vld_rf, vld_wf, vld_nc, busy_rf, busy_wf, busy_nc, err_rf, err_wf, err_nc;

    logic        en3 = 1'b0, we3 = 1'b0;
    logic [5:0]  addr3 = '0;
    logic [31:0] din3 = '0, dout3;
    logic        vld3, busy3, err3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ram_sp_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_MODE(RAM_READ_FIRST), .INIT_VALUE(8'hA5)) dut_rf (
        .clock(clock), .reset(reset), .enable_in(en), .we_in(we), .addr_in(addr), .data_in(din),
        .clear_in(clr), .data_out(dout_rf), .valid_out(vld_rf), .busy_out(busy_rf), .err_out(err_rf));
    ram_sp_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_MODE(RAM_WRITE_FIRST), .INIT_VALUE(8'hA5)) dut_wf (
        .clock(clock), .reset(reset), .enable_in(en), .we_in(we), .addr_in(addr), .data_in(din),
        .clear_in(clr), .data_out(dout_wf), .valid_out(vld_wf), .busy_out(busy_wf), .err_out(err_wf));
    ram_sp_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_MODE(RAM_NO_CHANGE), .INIT_VALUE(8'hA5)) dut_nc (
        .clock(clock), .reset(reset), .enable_in(en), .we_in(we), .addr_in(addr), .data_in(din),
        .clear_in(clr), .data_out(dout_nc), .valid_out(vld_nc), .busy_out(busy_nc), .err_out(err_nc));
    ram_sp_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WR_MODE(RAM_READ_FIRST), .INIT_VALUE(32'hDEADBEEF)) dut_w (
        .clock(clock), .reset(reset), .enable_in(en3), .we_in(we3), .addr_in(addr3), .data_in(din3),
        .clear_in(1'b0), .data_out(dout3), .valid_out(vld3), .busy_out(busy3), .err_out(err3));

    typedef struct {
        logic       en;
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] exp_rf;
        logic [7:0] exp_wf;
        logic [7:0] exp_nc;
        logic       exp_valid;
    } vec_t;

    vec_t vec [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] erf, input logic [7:0] ewf,
                           input logic [7:0] enc, input logic ev, input logic ee, input logic eb);
        chk({name, " data_rf"}, 32'(dout_rf), 32'(erf));
        chk({name, " data_wf"}, 32'(dout_wf), 32'(ewf));
        chk({name, " data_nc"}, 32'(dout_nc), 32'(enc));
        chk({name, " valid"}, {29'd0, vld_rf, vld_wf, vld_nc}, {29'd0, ev, ev, ev});
        chk({name, " err"},   {29'd0, err_rf, err_wf, err_nc}, {29'd0, ee, ee, ee});
        chk({name, " busy"},  {29'd0, busy_rf, busy_wf, busy_nc}, {29'd0, eb, eb, eb});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    logic [31:0] mdl3 [64];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Table: read every word after the initial clear, then write/read pairs
        // whose expected data_out differs per WR_MODE.
        for (int a = 0; a < 16; a++)
            vec[a] = '{1'b1, 1'b0, 4'(a), 8'h00, 8'hA5, 8'hA5, 8'hA5, 1'b1};
        vec[16] = '{1'b1, 1'b1, 4'd7, 8'h11, 8'hA5, 8'h11, 8'hA5, 1'b0};
        vec[17] = '{1'b1, 1'b0, 4'd7, 8'h00, 8'h11, 8'h11, 8'h11, 1'b1};
        vec[18] = '{1'b1, 1'b1, 4'd5, 8'h3C, 8'hA5, 8'h3C, 8'h11, 1'b0};
        vec[19] = '{1'b1, 1'b0, 4'd5, 8'h00, 8'h3C, 8'h3C, 8'h3C, 1'b1};
        vec[20] = '{1'b0, 1'b0, 4'd5, 8'h00, 8'h3C, 8'h3C, 8'h3C, 1'b0};

        // Reset state
        repeat (3) step();
        chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset busy32", 32'(busy3), 32'd1);
        reset = 1'b0;

        // Initial clear: 16 busy edges; read at edge 3 and write addr 0 at edge 4 are refused
        for (int e = 1; e <= 16; e++) begin
            idle();
            if (e == 3) begin en = 1'b1; we = 1'b0; addr = 4'd2; end
            if (e == 4) begin en = 1'b1; we = 1'b1; addr = 4'd0; din = 8'h77; end
            step();
            chk_all($sformatf("clear e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0,
                    (e == 3 || e == 4), (e < 16));
        end

        // Table-driven vectors
        for (int i = 0; i < 21; i++) begin
            en = vec[i].en; we = vec[i].we; addr = vec[i].addr; din = vec[i].din; clr = 1'b0;
            step();
            chk_all($sformatf("vec%0d", i), vec[i].exp_rf, vec[i].exp_wf, vec[i].exp_nc,
                    vec[i].exp_valid, 1'b0, 1'b0);
        end

        // Fill with FF, then a read together with clear_in; second clear_in mid-clear
        for (int a = 0; a < 16; a++) begin
            en = 1'b1; we = 1'b1; addr = 4'(a); din = 8'hFF;
            step();
        end
        chk_all("fill last", dout_rf, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0);
        en = 1'b1; we = 1'b0; addr = 4'd3; clr = 1'b1;
        step();
        chk_all("clr+read", 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            idle();
            if (j == 5) clr = 1'b1;
            step();
            chk_all($sformatf("reclear j%0d", j), 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, (j < 16));
        end
        for (int a = 0; a < 16; a++) begin
            en = 1'b1; we = 1'b0; addr = 4'(a); clr = 1'b0;
            step();
            chk_all($sformatf("post-clr rd%0d", a), 8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
        end

        // Reset during clear cycle 7
        idle(); clr = 1'b1;
        step();
        idle();
        repeat (6) step();
        chk_all("pre-reset", 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #2;
        chk_all("async reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        en = 1'b1; we = 1'b0; addr = 4'd1;
        step();
        chk_all("held reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        idle();
        reset = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            chk_all($sformatf("rst-clear j%0d", j), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, (j < 16));
        end
        en = 1'b1; we = 1'b0; addr = 4'd9;
        step();
        chk_all("rd after rst-clear", 8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle();

        // Wide instance: wait for its 64-word clear, then random full-rate traffic
        begin
            int guard;
            guard = 0;
            while (busy3 && guard < 100) begin
                step();
                guard++;
            end
            chk("wide clear done", 32'(busy3), 32'd0);
        end
        for (int k = 0; k < 64; k++) mdl3[k] = 32'hDEADBEEF;
        begin
            logic [31:0] exp_d;
            logic        exp_v;
            int          op, a;
            logic [31:0] d;
            exp_d = 32'd0;
            for (int i = 0; i < 400; i++) begin
                op = $urandom_range(0, 2);
                a  = $urandom_range(0, (i % 2) ? 63 : 15);
                d  = $urandom;
                en3 = (op != 0); we3 = (op == 2); addr3 = 6'(a); din3 = d;
                step();
                exp_v = (op == 1);
                if (op != 0) exp_d = mdl3[a];
                if (op == 2) mdl3[a] = d;
                chk($sformatf("rnd%0d data", i), dout3, exp_d);
                chk($sformatf("rnd%0d valid/err", i), {30'd0, vld3, err3}, {30'd0, exp_v, 1'b0});
            end
            en3 = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
